dmem_arbiter: RTL

//  Shares the single data-memory port between the core load/store path and the network loader.

---
 rtl/dmem_arbiter_pkg.sv | 44 ++++
 rtl/dmem_rr_picker.sv | 28 ++
 rtl/dmem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module  : dmem_arbiter_pkg
// Desc    : Shared memory command/response types and arbiter state encodings.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

   localparam int c_dataWidth = 32;

   typedef struct packed {
      logic [c_dataWidth-1:0] write_data;
      logic                   valid;
      logic                   wen;
      logic                   byte_not_word;
      logic                   yumi;
   } mem_in_s;

   typedef struct packed {
      logic [c_dataWidth-1:0] read_data;
      logic                   valid;
      logic                   yumi;
   } mem_out_s;

   typedef enum logic [1:0] {
      DMEM_IDLE      = 2'd0,
      DMEM_REQ_SENT  = 2'd1,
      DMEM_REQ_ACKED = 2'd2
   } dmem_req_state;

   // Enum value doubles as the bit index in the request/grant vectors.
   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_NET  = 1'b1
   } dmem_req_e;

   function automatic dmem_req_e otherReq(input dmem_req_e req);
      return (req == REQ_CORE) ? REQ_NET : REQ_CORE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_rr_picker.sv
// ============================================================================
// Module  : dmem_rr_picker
// Desc    : Two-way round-robin picker; one-hot grant, pointer breaks ties.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_rr_picker
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  dmem_req_e  pointer,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (pointer == REQ_CORE) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Desc    : Shares the data-memory port between core and network loader,
//           round-robin, one outstanding transaction. Optional watchdog is
//           built when DMEM_ARB_TIMEOUT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int addr_width_p     = 12,
   parameter int timeout_cycles_p = 256
)(
   input  logic                    clk,
   input  logic                    n_reset,
   input  logic [addr_width_p-1:0] core_addr_i,
   input  mem_in_s                 core_in_i,
   output mem_out_s                core_out_o,
   input  logic [addr_width_p-1:0] net_addr_i,
   input  mem_in_s                 net_in_i,
   output mem_out_s                net_out_o,
   output logic [addr_width_p-1:0] mem_addr_o,
   output mem_in_s                 mem_in_o,
   input  mem_out_s                mem_out_i,
   output logic                    grant_o,
   output logic                    busy_o,
   output logic                    error_o
);

   dmem_req_state             r_state;
   dmem_req_state             w_nextState;
   dmem_req_e                 r_pointer;
   dmem_req_e                 r_owner;
   dmem_req_e                 w_winner;
   logic [addr_width_p-1:0]   r_addr;
   logic [c_dataWidth-1:0]    r_wdata;
   logic                      r_wen;
   logic                      r_byteNotWord;
   logic [1:0]                w_req;
   logic [1:0]                w_pick;
   logic                      w_launch;
   logic                      w_ownerYumi;
   logic                      w_respDone;
   logic                      w_advance;
   logic                      w_timeout;
   logic                      w_timeoutFire;

   // Gating with n_reset keeps every output low while reset is held.
   assign w_req = {net_in_i.valid, core_in_i.valid} & {2{n_reset}};

   dmem_rr_picker u_picker (
      .req     (w_req),
      .pointer (r_pointer),
      .grant   (w_pick)
   );

   assign w_winner      = w_pick[1] ? REQ_NET : REQ_CORE;
   assign w_launch      = (r_state == DMEM_IDLE) && (|w_pick);
   assign w_ownerYumi   = (r_owner == REQ_NET) ? net_in_i.yumi : core_in_i.yumi;
   assign w_respDone    = (r_state == DMEM_REQ_ACKED) && mem_out_i.valid && w_ownerYumi;
   assign w_advance     = ((r_state == DMEM_REQ_SENT) && mem_out_i.yumi) || w_respDone;
   assign w_timeoutFire = w_timeout && !w_advance;

   // State register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= DMEM_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         DMEM_IDLE: begin
            if (|w_pick) begin
               w_nextState = DMEM_REQ_SENT;
            end
         end
         DMEM_REQ_SENT: begin
            // A response beat arriving alongside yumi is deliberately dropped.
            if (mem_out_i.yumi) begin
               w_nextState = DMEM_REQ_ACKED;
            end else if (w_timeoutFire) begin
               w_nextState = DMEM_IDLE;
            end
         end
         DMEM_REQ_ACKED: begin
            if (w_respDone || w_timeoutFire) begin
               w_nextState = DMEM_IDLE;
            end
         end
         default: w_nextState = DMEM_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      core_out_o = '0;
      net_out_o  = '0;
      mem_in_o   = '0;
      case (r_state)
         DMEM_IDLE: begin
            core_out_o.yumi = w_pick[0];
            net_out_o.yumi  = w_pick[1];
         end
         DMEM_REQ_SENT: begin
            mem_in_o.write_data    = r_wdata;
            mem_in_o.wen           = r_wen;
            mem_in_o.byte_not_word = r_byteNotWord;
            mem_in_o.valid         = 1'b1;
         end
         DMEM_REQ_ACKED: begin
            mem_in_o.yumi = w_ownerYumi & mem_out_i.valid;
            if (r_owner == REQ_CORE) begin
               core_out_o.read_data = mem_out_i.read_data;
               core_out_o.valid     = mem_out_i.valid;
            end else begin
               net_out_o.read_data  = mem_out_i.read_data;
               net_out_o.valid      = mem_out_i.valid;
            end
         end
         default: ;
      endcase
   end

   // Command/address latch and ownership captured at grant time
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wen         <= 1'b0;
         r_byteNotWord <= 1'b0;
         r_owner       <= REQ_CORE;
      end else if (w_launch) begin
         r_owner <= w_winner;
         if (w_winner == REQ_NET) begin
            r_addr        <= net_addr_i;
            r_wdata       <= net_in_i.write_data;
            r_wen         <= net_in_i.wen;
            r_byteNotWord <= net_in_i.byte_not_word;
         end else begin
            r_addr        <= core_addr_i;
            r_wdata       <= core_in_i.write_data;
            r_wen         <= core_in_i.wen;
            r_byteNotWord <= core_in_i.byte_not_word;
         end
      end
   end

   // Pointer moves away from the owner whenever a transaction ends, even on timeout.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_pointer <= REQ_CORE;
      end else if (w_respDone || w_timeoutFire) begin
         r_pointer <= otherReq(r_owner);
      end
   end

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int c_timerWidth = $clog2(timeout_cycles_p + 1);
   localparam logic [c_timerWidth-1:0] c_timerLast = c_timerWidth'(timeout_cycles_p - 1);

   logic [c_timerWidth-1:0] r_timer;
   logic                    r_error;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_timer <= '0;
      end else if ((r_state == DMEM_IDLE) || (w_nextState != r_state)) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + c_timerWidth'(1);
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_error <= 1'b0;
      end else if (w_timeoutFire) begin
         r_error <= 1'b1;
      end
   end

   assign w_timeout = (r_state != DMEM_IDLE) && (r_timer == c_timerLast);
   assign error_o   = r_error;
`else
   assign w_timeout = 1'b0;
   assign error_o   = 1'b0;
`endif

   assign mem_addr_o = r_addr;
   assign grant_o    = r_owner;
   assign busy_o     = (r_state != DMEM_IDLE);

endmodule

`default_nettype wire
